// File: rtl/wimax_cc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : wimax_cc_encoder
// Description : Rate-1/2 tail-biting convolutional encoder (K=7,
//               G1=171 octal -> X, G2=133 octal -> Y). Serial input bits are
//               collected into a two-bank ping-pong buffer of BLOCK_BITS bits.
//               Each full bank has its shift register preloaded with the
//               block's last six bits. The bank is then emitted as X/Y pairs
//               in bit order 0..N-1.
// Ports       : clk, reset_N (async, active low), clr (sync abort)
//               in_valid/in_ready/in_data     : serial randomized bit input
//               out_valid/out_ready           : coded pair handshake
//               out_x/out_y                   : G1/G2 coded bits
//               out_sob/out_eob               : first / last pair of block
// Revision    : 1.0 - initial release
// ============================================================================
module wimax_cc_encoder #(
  parameter int BLOCK_BITS = 96,
  parameter int PTR_W      = $clog2(BLOCK_BITS)
) (
  input  logic clk,
  input  logic reset_N,
  input  logic clr,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_x,
  output logic out_y,
  output logic out_sob,
  output logic out_eob
);

  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(BLOCK_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_ENCODE  = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [1:0]              full_q,    full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [PTR_W-1:0]        wr_ptr_q,  wr_ptr_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0]        rd_ptr_q,  rd_ptr_d;
  // sr_q[k] is the input bit delayed by k+1
  logic [5:0]              sr_q,      sr_d;
  logic [BLOCK_BITS-1:0]   bank_q [2];
  logic [BLOCK_BITS-1:0]   bank_d [2];

  logic [BLOCK_BITS-1:0]   w_rd_word;
  logic                    w_cur_bit;
  logic [5:0]              w_preload;
  logic                    w_wr_fire;
  logic                    w_out_fire;

  assign w_rd_word  = bank_q[rd_bank_q];
  assign w_cur_bit  = w_rd_word[rd_ptr_q];
  assign in_ready   = !full_q[wr_bank_q];
  assign w_wr_fire  = in_valid && in_ready;
  assign out_valid  = (state_q == ST_ENCODE);
  assign w_out_fire = out_valid && out_ready;

  // Tail-biting start state: s0 = b[N-1] ... s5 = b[N-6]
  always_comb begin
    w_preload = '0;
    for (int k = 0; k < 6; k++) begin
      w_preload[k] = w_rd_word[BLOCK_BITS-1-k];
    end
  end

  assign out_x   = out_valid & (w_cur_bit ^ sr_q[0] ^ sr_q[1] ^ sr_q[2] ^ sr_q[5]);
  assign out_y   = out_valid & (w_cur_bit ^ sr_q[1] ^ sr_q[2] ^ sr_q[4] ^ sr_q[5]);
  assign out_sob = out_valid && (rd_ptr_q == '0);
  assign out_eob = out_valid && (rd_ptr_q == C_LAST_PTR);

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    sr_d      = sr_q;
    bank_d    = bank_q;

    if (clr) begin
      state_d   = ST_IDLE;
      full_d    = '0;
      wr_bank_d = 1'b0;
      wr_ptr_d  = '0;
      rd_bank_d = 1'b0;
      rd_ptr_d  = '0;
      sr_d      = '0;
    end else begin
      if (w_wr_fire) begin
        bank_d[wr_bank_q][wr_ptr_q] = in_data;
        if (wr_ptr_q == C_LAST_PTR) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
          wr_ptr_d          = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_bank_q]) state_d = ST_PRELOAD;
        end
        ST_PRELOAD: begin
          sr_d     = w_preload;
          rd_ptr_d = '0;
          state_d  = ST_ENCODE;
        end
        ST_ENCODE: begin
          if (w_out_fire) begin
            sr_d     = {sr_q[4:0], w_cur_bit};
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == C_LAST_PTR) begin
              full_d[rd_bank_q] = 1'b0;
              rd_bank_d         = !rd_bank_q;
              rd_ptr_d          = '0;
              // full_d already reflects a fill completing on this same edge,
              // so a just-finished bank costs only the single preload bubble.
              state_d = full_d[!rd_bank_q] ? ST_PRELOAD : ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= ST_IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      sr_q      <= sr_d;
    end
  end

  // Bank contents are qualified by the full flags, so they need no reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_wimax_cc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wimax_cc_encoder
// Description : Scoreboard bench for wimax_cc_encoder. The stimulus pushes
//               expected {x,y,sob,eob} pairs into a queue. A monitor pops and
//               compares them on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wimax_cc_encoder;

  localparam int N = 96;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_x, out_y, out_sob, out_eob;

  wimax_cc_encoder #(.BLOCK_BITS(N)) dut (
    .clk(clk), .reset_N(reset_N), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_sob(out_sob), .out_eob(out_eob)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pops = 0;
  int eob_seen = 0;
  int acc = 0;
  int bub = 0;
  bit bubble_chk = 1'b0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;
  logic ready_fixed = 1'b0;
  bit hold_pend = 1'b0;
  logic [3:0] held;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // out_ready driver: sole writer, at posedge+2 so it never races the edge
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Monitor: sampled on the falling edge, between active edges
  always @(negedge clk) begin
    logic [3:0] cur;
    logic [3:0] e;
    cur = {out_x, out_y, out_sob, out_eob};
    if (mon_en) begin
      if (bub == 2) begin chk("bubble_sob", {out_valid, out_sob}, 2'b11); bub = 0; end
      if (bub == 1) begin chk("bubble_gap", out_valid, 1'b0); bub = 2; end
      if (hold_pend && out_valid) chk("hold_stable", cur, held);
      if (out_valid && out_eob) eob_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("pair%0d_xy_sob_eob", pops), cur, e);
        end
        pops++;
        if (out_eob && bubble_chk) begin bub = 1; bubble_chk = 1'b0; end
      end
      hold_pend = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic push_pair(input logic x, input logic y, input int i);
    exp_q.push_back({x, y, (i == 0) ? 1'b1 : 1'b0, (i == N-1) ? 1'b1 : 1'b0});
  endtask

  // Reference tail-biting encoder
  task automatic push_model(input logic [N-1:0] blk);
    logic [5:0] s;
    logic b;
    for (int k = 0; k < 6; k++) s[k] = blk[N-1-k];
    for (int i = 0; i < N; i++) begin
      b = blk[i];
      push_pair(b ^ s[0] ^ s[1] ^ s[2] ^ s[5], b ^ s[1] ^ s[2] ^ s[4] ^ s[5], i);
      s = {s[4:0], b};
    end
  endtask

  task automatic send_bit(input logic b, input int max_wait);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int w = 0; w < max_wait; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc++;
    end else begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [N-1:0] blk, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_bit(blk[i], 400);
    end
  endtask

  task automatic drain(input int budget);
    for (int w = 0; w < budget && exp_q.size() != 0; w++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_blk();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] blk;
    logic [6:0] imp0_x, imp0_y;
    logic [5:0] imp95_x, imp95_y;
    int base, e0;
    bit ok;
    imp0_x  = 7'b1001111;   // pairs 0..6 : 1,1,1,1,0,0,1
    imp0_y  = 7'b1101101;   // pairs 0..6 : 1,0,1,1,0,1,1
    imp95_x = 6'b100111;    // pairs 0..5 : 1,1,1,0,0,1
    imp95_y = 6'b110110;    // pairs 0..5 : 0,1,1,0,1,1

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outs", {out_valid, out_x, out_y, out_sob, out_eob}, 5'b0);
    reset_N = 1'b1;
    mon_en = 1'b1;
    ready_fixed = 1'b1;
    @(posedge clk); #1;

    // All-zero block with latency check
    blk = '0;
    push_model(blk);
    for (int i = 0; i < N; i++) send_bit(1'b0, 50);
    @(negedge clk); chk("lat_idle", out_valid, 1'b0);
    @(negedge clk); chk("lat_preload", out_valid, 1'b0);
    @(negedge clk); chk("lat_encode", {out_valid, out_sob}, 2'b11);
    drain(400);

    // Impulse at bit 0
    blk = '0; blk[0] = 1'b1;
    for (int i = 0; i < N; i++)
      push_pair((i < 7) ? imp0_x[i] : 1'b0, (i < 7) ? imp0_y[i] : 1'b0, i);
    send_block(blk, 1'b0);
    drain(400);

    // Impulse at bit 95 (tail-biting wrap)
    blk = '0; blk[N-1] = 1'b1;
    for (int i = 0; i < N; i++)
      push_pair((i < 6) ? imp95_x[i] : (i == N-1), (i < 6) ? imp95_y[i] : (i == N-1), i);
    send_block(blk, 1'b0);
    drain(400);

    // Backpressure: both banks fill, pair 0 held
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    acc = 0;
    blk = rand_blk(); push_model(blk); send_block(blk, 1'b0);
    blk = rand_blk(); push_model(blk); send_block(blk, 1'b0);
    chk("acc_before_full", acc, 192);
    repeat (10) begin @(negedge clk); chk("in_ready_full", in_ready, 1'b0); end
    blk = rand_blk(); push_model(blk);
    bubble_chk = 1'b1;
    @(posedge clk); #1;
    base = pops;
    ready_fixed = 1'b1;
    in_valid = 1'b1; in_data = blk[0]; ok = 1'b0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("recover_ok", ok, 1'b1);
    chk("pops_at_recover", pops - base, 96);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < N; i++) send_bit(blk[i], 400);
    drain(800);
    chk("bubble_checked", bub + int'(bubble_chk), 0);

    // Random block traffic
    rand_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      blk = rand_blk(); push_model(blk); send_block(blk, 1'b1);
    end
    drain(3000);
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // clr at pair 40
    blk = rand_blk(); push_model(blk); send_block(blk, 1'b0);
    base = pops; e0 = eob_seen; ok = 1'b0;
    for (int w = 0; w < 400; w++) begin
      @(posedge clk); #1;
      if (pops - base == 40) begin ok = 1'b1; break; end
    end
    chk("reach_pair40", ok, 1'b1);
    clr = 1'b1; ready_fixed = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; ready_fixed = 1'b1;
    exp_q.delete();
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("clr_no_eob", eob_seen - e0, 0);
    blk = rand_blk(); push_model(blk); send_block(blk, 1'b0);
    drain(400);

    // reset_N pulsed mid-fill
    blk = rand_blk();
    for (int i = 0; i < 50; i++) send_bit(blk[i], 50);
    #2;
    reset_N = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    reset_N = 1'b1;
    e0 = eob_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_eob", eob_seen - e0, 0);
    blk = rand_blk(); push_model(blk); send_block(blk, 1'b1);
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
